// File: rtl/main_memory.sv
// main_memory: word-serial main-memory responder at the RAM end of the L2
// refill/writeback interface. Single-beat word writes go straight into an
// on-chip word array. A read request triggers a BURST_LEN-word line-fill
// burst after a programmable latency, and each beat is marked by ram_valid.
//
// Ports:
//   clk           clock; all state changes on the rising edge
//   reset         asynchronous, active-high reset
//   ram_addr      word address (low ADDR_W bits used, upper bits alias)
//   ram_read_en   read-burst request, held high for the whole burst
//   ram_write_en  write strobe, one word per cycle while high
//   ram_data_in   write data
//   ram_data      read data beat (holds its last value when not valid)
//   ram_valid     ram_data carries a burst beat this cycle
//   ram_ready     responder can accept a new read or write
//
// Optional feature, macro MAIN_MEM_STATS_EN:
//   stat_rd_bursts  completed read bursts (saturating at 16'hFFFF)
//   stat_wr_words   words written into the array (saturating at 16'hFFFF)
module main_memory #(
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 2,
    parameter int BURST_LEN    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] ram_addr,
    input  logic        ram_read_en,
    input  logic        ram_write_en,
    input  logic [31:0] ram_data_in,
    output logic [31:0] ram_data,
    output logic        ram_valid,
    output logic        ram_ready
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [15:0] stat_rd_bursts,
    output logic [15:0] stat_wr_words
`endif
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    localparam logic [3:0]        LAT_LAST  = 4'(READ_LATENCY - 1);
    localparam logic [BEAT_W-1:0] BEAT_END  = BEAT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        RD_WAIT  = 2'd2,
        RD_BURST = 2'd3
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   base_r;
    logic [BEAT_W-1:0]   beat_r;
    logic [3:0]          lat_r;
    logic [31:0]         mem_r [0:DEPTH-1];

    logic [ADDR_W-1:0]   wr_idx_s;
    logic [ADDR_W-1:0]   rd_idx_s;
    logic [31:0]         rd_word_s;
    logic                wr_fire_s;
    logic                last_beat_s;

    assign wr_idx_s  = ram_addr[ADDR_W-1:0];
    // Burst address wraps naturally at the array depth through ADDR_W-bit addition.
    assign rd_idx_s  = base_r + ADDR_W'(beat_r);
    assign rd_word_s = mem_r[rd_idx_s];

    // Decode which edges commit a word to the array and which issue the final beat.
    always_comb begin
        wr_fire_s   = 1'b0;
        last_beat_s = 1'b0;
        case (state_r)
            IDLE: begin
                // A write only lands once the responder is ready (not on the
                // first edge after reset).
                if (ram_ready && ram_write_en) begin
                    wr_fire_s = 1'b1;
                end else begin
                    wr_fire_s = 1'b0;
                end
            end
            WRITE: begin
                wr_fire_s = ram_write_en;
            end
            RD_WAIT: begin
                if (ram_read_en && (lat_r == LAT_LAST) && (BEAT_LAST == {BEAT_W{1'b0}})) begin
                    last_beat_s = 1'b1;
                end else begin
                    last_beat_s = 1'b0;
                end
            end
            RD_BURST: begin
                if (ram_read_en && (beat_r == BEAT_LAST)) begin
                    last_beat_s = 1'b1;
                end else begin
                    last_beat_s = 1'b0;
                end
            end
            default: begin
                wr_fire_s   = 1'b0;
                last_beat_s = 1'b0;
            end
        endcase
    end

    // Word array: deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[wr_idx_s] <= ram_data_in;
        end
    end

    // Request/burst sequencer with registered handshake and data outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            base_r    <= {ADDR_W{1'b0}};
            beat_r    <= {BEAT_W{1'b0}};
            lat_r     <= 4'd0;
            ram_data  <= 32'd0;
            ram_valid <= 1'b0;
            ram_ready <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!ram_ready) begin
                        ram_ready <= 1'b1;
                    end else if (ram_write_en) begin
                        // Write wins over a simultaneous read.
                        state_r <= WRITE;
                    end else if (ram_read_en) begin
                        base_r    <= wr_idx_s;
                        lat_r     <= 4'd0;
                        beat_r    <= {BEAT_W{1'b0}};
                        ram_ready <= 1'b0;
                        state_r   <= RD_WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WRITE: begin
                    if (!ram_write_en) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WRITE;
                    end
                end
                RD_WAIT: begin
                    if (!ram_read_en) begin
                        ram_valid <= 1'b0;
                        ram_ready <= 1'b1;
                        state_r   <= IDLE;
                    end else if (lat_r == LAT_LAST) begin
                        // The final wait edge already issues beat 0, so beat 0
                        // appears READ_LATENCY edges after acceptance.
                        ram_data  <= rd_word_s;
                        ram_valid <= 1'b1;
                        beat_r    <= beat_r + BEAT_W'(1);
                        lat_r     <= lat_r + 4'd1;
                        state_r   <= RD_BURST;
                    end else begin
                        lat_r <= lat_r + 4'd1;
                    end
                end
                RD_BURST: begin
                    if (!ram_read_en || (beat_r == BEAT_END)) begin
                        // Completion or abort: ram_data keeps the last beat.
                        ram_valid <= 1'b0;
                        ram_ready <= 1'b1;
                        beat_r    <= {BEAT_W{1'b0}};
                        state_r   <= IDLE;
                    end else begin
                        ram_data  <= rd_word_s;
                        ram_valid <= 1'b1;
                        beat_r    <= beat_r + BEAT_W'(1);
                    end
                end
                default: begin
                    ram_valid <= 1'b0;
                    ram_ready <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

`ifdef MAIN_MEM_STATS_EN
    // Saturating activity counters; bursts count only when the final beat issues.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_rd_bursts <= 16'd0;
            stat_wr_words  <= 16'd0;
        end else begin
            if (wr_fire_s && (stat_wr_words != 16'hFFFF)) begin
                stat_wr_words <= stat_wr_words + 16'd1;
            end else begin
                stat_wr_words <= stat_wr_words;
            end
            if (last_beat_s && (stat_rd_bursts != 16'hFFFF)) begin
                stat_rd_bursts <= stat_rd_bursts + 16'd1;
            end else begin
                stat_rd_bursts <= stat_rd_bursts;
            end
        end
    end
`endif

endmodule

// File: tb/tb_main_memory.sv
module tb_main_memory;

    logic        clk;
    logic        reset;
    logic [29:0] ram_addr;
    logic        ram_read_en;
    logic        ram_write_en;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data;
    logic        ram_valid;
    logic        ram_ready;
`ifdef MAIN_MEM_STATS_EN
    logic [15:0] stat_rd_bursts;
    logic [15:0] stat_wr_words;
`endif

    int checks;
    int errors;

    // Reference contents of every word the bench has written.
    logic [31:0] model [0:4095];

    main_memory dut (
        .clk          (clk),
        .reset        (reset),
        .ram_addr     (ram_addr),
        .ram_read_en  (ram_read_en),
        .ram_write_en (ram_write_en),
        .ram_data_in  (ram_data_in),
        .ram_data     (ram_data),
        .ram_valid    (ram_valid),
        .ram_ready    (ram_ready)
`ifdef MAIN_MEM_STATS_EN
        ,
        .stat_rd_bursts (stat_rd_bursts),
        .stat_wr_words  (stat_wr_words)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One write beat; leaves write_en high so consecutive calls stream.
    task automatic wr(input logic [29:0] addr, input logic [31:0] data);
        ram_write_en = 1'b1;
        ram_addr     = addr;
        ram_data_in  = data;
        tick();
        model[addr[11:0]] = data;
    endtask

    task automatic wr_end();
        ram_write_en = 1'b0;
        tick();
        check("wr_end_ready", {31'd0, ram_ready}, 32'd1);
    endtask

    // Read burst from addr; check nbeats beats, then drop read_en.
    task automatic rd(input logic [29:0] addr, input int nbeats);
        logic [11:0] idx;
        ram_addr    = addr;
        ram_read_en = 1'b1;
        tick();
        check("rd_accept_ready", {31'd0, ram_ready}, 32'd0);
        check("rd_accept_valid", {31'd0, ram_valid}, 32'd0);
        ram_addr = ~addr;
        tick();
        check("rd_wait_valid", {31'd0, ram_valid}, 32'd0);
        for (int b = 0; b < nbeats; b++) begin
            tick();
            idx = addr[11:0] + 12'(b);
            check("rd_beat_valid", {31'd0, ram_valid}, 32'd1);
            check($sformatf("rd_beat%0d_data", b), ram_data, model[idx]);
        end
        ram_read_en = 1'b0;
        tick();
        idx = addr[11:0] + 12'(nbeats - 1);
        check("rd_end_valid", {31'd0, ram_valid}, 32'd0);
        check("rd_end_ready", {31'd0, ram_ready}, 32'd1);
        check("rd_end_hold", ram_data, model[idx]);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        ram_addr     = 30'd0;
        ram_read_en  = 1'b0;
        ram_write_en = 1'b0;
        ram_data_in  = 32'd0;

        // Reset values
        #1;
        check("rst_ready", {31'd0, ram_ready}, 32'd0);
        check("rst_valid", {31'd0, ram_valid}, 32'd0);
        check("rst_data", ram_data, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rel_ready_before_edge", {31'd0, ram_ready}, 32'd0);
        tick();
        check("rel_ready_after_edge", {31'd0, ram_ready}, 32'd1);

        // Write then read
        for (int i = 0; i < 16; i++) begin
            wr(30'h40 + 30'(i), 32'h1000_0000 + 32'(i));
        end
        wr_end();
        rd(30'h40, 16);
        check("w_then_r_beat15", ram_data, 32'h1000_000F);
`ifdef MAIN_MEM_STATS_EN
        check("stat_wr_words_16", {16'd0, stat_wr_words}, 32'd16);
        check("stat_rd_bursts_1", {16'd0, stat_rd_bursts}, 32'd1);
`endif

        // Wrap around the top of the array, base given with aliased upper bits
        for (int i = 0; i < 8; i++) begin
            wr(30'hFF8 + 30'(i), 32'hA000_0FF8 + 32'(i));
        end
        for (int i = 0; i < 8; i++) begin
            wr(30'(i), 32'hB000_0000 + 32'(i));
        end
        wr_end();
        rd(30'h2000_0FF8, 16);
        check("wrap_last_from_0x007", ram_data, 32'hB000_0007);

        // Simultaneous read and write in IDLE: write wins
        ram_addr     = 30'h10;
        ram_data_in  = 32'hDEAD_BEEF;
        ram_write_en = 1'b1;
        ram_read_en  = 1'b1;
        tick();
        model[12'h010] = 32'hDEAD_BEEF;
        check("simul_valid", {31'd0, ram_valid}, 32'd0);
        check("simul_ready", {31'd0, ram_ready}, 32'd1);
        ram_read_en = 1'b0;
        wr_end();
        rd(30'h10, 1);
        check("simul_beat0", ram_data, 32'hDEAD_BEEF);

        // Write strobe during a burst is ignored
        ram_addr    = 30'h40;
        ram_read_en = 1'b1;
        tick();
        ram_write_en = 1'b1;
        ram_data_in  = 32'h5555_AAAA;
        repeat (4) tick();
        ram_write_en = 1'b0;
        ram_read_en  = 1'b0;
        tick();
        check("wr_in_burst_ready", {31'd0, ram_ready}, 32'd1);

        // Abort after the 5th beat, then a full read of the same line
        rd(30'h40, 5);
        check("abort_hold_beat4", ram_data, 32'h1000_0004);
`ifdef MAIN_MEM_STATS_EN
        check("stat_rd_bursts_after_abort", {16'd0, stat_rd_bursts}, 32'd2);
        check("stat_wr_words_33", {16'd0, stat_wr_words}, 32'd33);
`endif
        rd(30'h40, 16);

        // Asynchronous reset during beat 7
        ram_addr    = 30'h40;
        ram_read_en = 1'b1;
        repeat (2) tick();
        for (int b = 0; b < 8; b++) begin
            tick();
        end
        check("pre_rst_beat7", ram_data, 32'h1000_0007);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, ram_valid}, 32'd0);
        check("async_rst_data", ram_data, 32'd0);
        check("async_rst_ready", {31'd0, ram_ready}, 32'd0);
        ram_read_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, ram_ready}, 32'd1);
`ifdef MAIN_MEM_STATS_EN
        check("stat_wr_cleared", {16'd0, stat_wr_words}, 32'd0);
        check("stat_rd_cleared", {16'd0, stat_rd_bursts}, 32'd0);
`endif
        rd(30'h40, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
